// File: rtl/code_filter_pkg.sv
// Shared definitions for the code filter arbiter: code width, whitelist set and FSM encoding.
package code_filter_pkg;

    localparam int CODE_W = 4;

    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Bit n set means code n is accepted: {3,4,6,8,9,10,13}
    localparam logic [15:0] WHITELIST = 16'h2758;

    function automatic logic is_whitelisted(input code_t c);
        return WHITELIST[c];
    endfunction

endpackage

// File: rtl/code_whitelist.sv
// Combinational whitelist filter: passes accepted codes through, zeroes everything else.
module code_whitelist
    import code_filter_pkg::*;
(
    input  code_t code,
    output code_t result,
    output logic  match
);

    assign match  = is_whitelisted(code);
    assign result = match ? code : '0;

endmodule

// File: rtl/code_filter_arbiter.sv
// Two-requester round-robin arbiter feeding one shared code whitelist filter.
// Optional saturating match counters are built when CODE_FILTER_ARB_CNT_EN is defined.
module code_filter_arbiter
    import code_filter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [3:0]       code0,
    input  logic             req1,
    input  logic [3:0]       code1,
    output logic [1:0]       gnt,
    output logic             ack,
    output logic             ack_id,
    output logic [3:0]       result,
    output logic             match,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    state_t state, state_nxt;
    logic   ptr;
    logic   id_q;
    code_t  code_q;
    code_t  res_q;
    logic   match_q;
    logic   pick;
    code_t  flt_res;
    logic   flt_match;

    // Contention is settled by the round-robin pointer; a lone request always wins.
    assign pick = (req0 & req1) ? ptr : req1;

    code_whitelist u_wl (
        .code   (code_q),
        .result (flt_res),
        .match  (flt_match)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req0 | req1) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt    = 2'b00;
        ack    = 1'b0;
        ack_id = 1'b0;
        result = '0;
        match  = 1'b0;
        busy   = 1'b0;
        case (state)
            ST_GRANT: begin
                gnt  = id_q ? 2'b10 : 2'b01;
                busy = 1'b1;
            end
            ST_RESP: begin
                ack    = 1'b1;
                ack_id = id_q;
                result = res_q;
                match  = match_q;
                busy   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= 1'b0;
            id_q    <= 1'b0;
            code_q  <= '0;
            res_q   <= '0;
            match_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        id_q   <= pick;
                        code_q <= pick ? code1 : code0;
                    end
                end
                ST_GRANT: begin
                    res_q   <= flt_res;
                    match_q <= flt_match;
                end
                ST_RESP: ptr <= ~id_q;
                default: ;
            endcase
        end
    end

`ifdef CODE_FILTER_ARB_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Updated alongside match_q so the new count is visible in the same cycle as ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (state == ST_GRANT && flt_match) begin
            if (!id_q && cnt0_q != '1) cnt0_q <= cnt0_q + CNT_W'(1);
            if (id_q && cnt1_q != '1)  cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: doc/code_filter_arbiter.md
CODE_FILTER_ARBITER -- requirements
Module: code_filter_arbiter

Interface
REQ-001 Parameter: CNT_W, 8, width of the per-requester match counters.
REQ-002 Port: clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req0  input  1  requester 0 request; held high until ack with ack_id=0.
REQ-005 Port: code0  input  4  requester 0 code; stable while req0 is high.
REQ-006 Port: req1  input  1  requester 1 request; same rules as req0.
REQ-007 Port: code1  input  4  requester 1 code.
REQ-008 Port: gnt  output  2  one-hot grant; bit n is high for the GRANT cycle of requester n.
REQ-009 Port: ack  output  1  one-cycle completion pulse.
REQ-010 Port: ack_id  output  1  requester served; valid only while ack is high.
REQ-011 Port: result  output  4  filtered code; valid only while ack is high.
REQ-012 Port: match  output  1  code is whitelisted; valid only while ack is high.
REQ-013 Port: busy  output  1  high in the GRANT and RESP states.
REQ-014 Port: cnt0  output  CNT_W  saturating count of matched requests from requester 0.
REQ-015 Port: cnt1  output  CNT_W  saturating count of matched requests from requester 1.

Function
REQ-016 FSM states: IDLE, GRANT, RESP.
- IDLE->GRANT when req0|req1.
- GRANT->RESP unconditionally.
- RESP->IDLE unconditionally.
REQ-017 IDLE selection:
- A single active request wins.
- If both are active, the requester named by priority pointer ptr wins.
- The winner's id and code are captured into internal registers.
REQ-018 GRANT: gnt[id]=1 for exactly one cycle; the captured code drives the whitelist filter; filter outputs are registered at the end of GRANT.
REQ-019 RESP: ack=1, ack_id=id, result/match come from the registers for exactly one cycle; ptr becomes ~id (round-robin).
REQ-020 Latency: a request sampled high in IDLE at edge N gives gnt after edge N, ack after edge N+1; one transaction per 3 cycles at most.
REQ-021 Whitelist: code in {3,4,6,8,9,10,13} -> result=code, match=1; any other code -> result=0, match=0.
REQ-022 Outside RESP: ack=0, match=0, result=0, ack_id=0.
REQ-023 Dropping req after capture does not abort; the transaction completes and is acked.
REQ-024 Code changes after capture are ignored.
REQ-025 A request still high in the cycle after RESP is treated as a new request.
REQ-026 Counters: cnt[id] increments by 1 on the RESP cycle when match=1; it saturates at 2^CNT_W-1 and never wraps.
REQ-027 Starvation freedom: with both requests held high continuously, grants alternate 0,1,0,1,...

Reset
REQ-028 When rst=1 at a clock edge:
- state=IDLE, ptr=0 (requester 0 favoured).
- gnt=0, ack=0, ack_id=0, result=0, match=0, busy=0, cnt0=0, cnt1=0.
REQ-029 Reset in GRANT or RESP abandons the transaction: no ack is produced and no counter changes.

Configuration
REQ-030 Macro CODE_FILTER_ARB_CNT_EN selects the match counters.
- Defined: counters are implemented per REQ-026.
- Undefined: no counter registers are built; cnt0 and cnt1 are driven constant 0.
- All other behaviour is identical either way.

Structure
REQ-031 Shared package code_filter_pkg holds:
- The whitelist constant set.
- The 4-bit code width.
- The FSM state encoding (IDLE=0, GRANT=1, RESP=2, 2-bit).
REQ-032 Sub-module code_whitelist: combinational 4-bit code -> {result, match}, instantiated once and shared by both requesters.

Verification
REQ-033 Reset, then req0=1, code0=4'b0110 -> gnt=2'b01 one cycle later; the next cycle gives ack=1, ack_id=0, result=6, match=1, cnt0=1.
REQ-034 req1=1, code1=4'b0101 -> ack with ack_id=1, result=0, match=0; cnt1 unchanged.
REQ-035 Both requests held high, 6 transactions -> ack_id sequence 0,1,0,1,0,1.
REQ-036 rst=1 in the cycle after gnt -> no ack follows; all outputs are 0 the next cycle; a following simultaneous request is granted to requester 0.
REQ-037 CNT_W=2, requester 0 issues 5 matched requests (code 13) -> cnt0 reads 1,2,3,3,3.
REQ-038 Build without CODE_FILTER_ARB_CNT_EN and repeat REQ-033 -> identical ack/result/match; cnt0=0.
